// File: rtl/plic_lite.sv
// Platform-level interrupt arbiter: per-source level gateways, priority/enable/threshold
// registers and a claim/complete handshake feeding the CPU's machine external interrupt line.
module plic_lite #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   irq_src,
    input  logic [11:0]       addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic              wenable,
    input  logic              renable,
    output logic [XLEN-1:0]   rdata,
    output logic              mei_pending
);

    localparam logic [9:0] W_PEND  = 10'h020;
    localparam logic [9:0] W_EN    = 10'h040;
    localparam logic [9:0] W_THR   = 10'h080;
    localparam logic [9:0] W_CLAIM = 10'h081;

    // Bit gi of every per-source vector belongs to source ID gi+1.
    logic [NSRC-1:0][PRIO_W-1:0] prio_reg, prio_next;
    logic [NSRC-1:0]             enable_reg, enable_next;
    logic [PRIO_W-1:0]           thr_reg, thr_next;
    logic [NSRC-1:0]             pending_reg, pending_next;
    logic [NSRC-1:0]             inflight_reg, inflight_next;
    logic [NSRC-1:0]             claim_hit, cpl_hit;
    logic [9:0]                  word;
    logic                        rd_stb, claim, complete;
    logic [4:0]                  best_id;
    logic [XLEN-1:0]             rd_mux;
    logic                        unused_bits;

    // Highest priority strictly above the threshold wins; ascending scan keeps the lowest ID on ties.
    function automatic logic [4:0] pick(
        input logic [NSRC-1:0]             pend,
        input logic [NSRC-1:0]             en,
        input logic [NSRC-1:0][PRIO_W-1:0] pr,
        input logic [PRIO_W-1:0]           thr
    );
        logic [PRIO_W-1:0] top;
        logic [4:0]        id;
        top = thr;
        id  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (pend[i] && en[i] && (pr[i] > top)) begin
                top = pr[i];
                id  = 5'(i + 1);
            end
        end
        return id;
    endfunction

    assign word        = addr[11:2];
    assign unused_bits = ^{addr[1:0], wdata};
    assign rd_stb      = renable && !wenable;
    assign claim       = rd_stb && (word == W_CLAIM);
    assign complete    = wenable && (word == W_CLAIM);
    assign best_id     = pick(pending_reg, enable_reg, prio_reg, thr_reg);
    assign enable_next = (wenable && word == W_EN) ? wdata[NSRC:1] : enable_reg;
    assign thr_next    = (wenable && word == W_THR) ? wdata[PRIO_W-1:0] : thr_reg;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign claim_hit[gi]     = claim && (best_id == 5'(gi + 1));
        assign cpl_hit[gi]       = complete && inflight_reg[gi] && (wdata[4:0] == 5'(gi + 1));
        assign prio_next[gi]     = (wenable && word == 10'(gi + 1)) ? wdata[PRIO_W-1:0] : prio_reg[gi];
        // A completing source passes through IDLE, so a held level re-pends one edge later.
        assign pending_next[gi]  = pending_reg[gi] ? !claim_hit[gi]
                                                   : (!inflight_reg[gi] && irq_src[gi]);
        assign inflight_next[gi] = inflight_reg[gi] ? !cpl_hit[gi] : claim_hit[gi];
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (word == 10'(i + 1)) rd_mux = XLEN'(prio_reg[i]);
        end
        if (word == W_PEND)  rd_mux = XLEN'({pending_reg, 1'b0});
        if (word == W_EN)    rd_mux = XLEN'({enable_reg, 1'b0});
        if (word == W_THR)   rd_mux = XLEN'(thr_reg);
        if (word == W_CLAIM) rd_mux = XLEN'(best_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg     <= '0;
            enable_reg   <= '0;
            thr_reg      <= '0;
            pending_reg  <= '0;
            inflight_reg <= '0;
            rdata        <= '0;
            mei_pending  <= 1'b0;
        end else begin
            prio_reg     <= prio_next;
            enable_reg   <= enable_next;
            thr_reg      <= thr_next;
            pending_reg  <= pending_next;
            inflight_reg <= inflight_next;
            if (rd_stb) rdata <= rd_mux;
            // Claims and register writes reach the line at once; fresh source edges wait one
            // edge in the gateway, giving the two-cycle source-to-line latency.
            mei_pending  <= (pick(pending_reg & ~claim_hit, enable_next, prio_next, thr_next) != 5'd0);
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: stimulus queues expected read data and line levels,
// a negedge monitor pops and compares them against the DUT.
module tb_plic_lite;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wenable;
    logic        renable;
    logic [31:0] rdata;
    logic        mei_pending;

    always #5 clk = ~clk;

    plic_lite #(.NSRC(8), .PRIO_W(3), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .addr        (addr),
        .wdata       (wdata),
        .wenable     (wenable),
        .renable     (renable),
        .rdata       (rdata),
        .mei_pending (mei_pending)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t mei_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic rd_seen  = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s got=0x%0h", name, act);
        end else begin
            $display("FAIL %s got=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) rd_seen <= renable && !wenable;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read got=0x%0h required=no read", rdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, rdata, e.val);
            end
        end
        while (mei_q.size() > 0) begin
            e = mei_q.pop_front();
            check(e.name, {31'b0, mei_pending}, e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e);
        exp_t x;
        x.name = $sformatf("rd_%03h", a);
        x.val  = e;
        rd_q.push_back(x);
        addr    = a;
        renable = 1'b1;
        tick();
        renable = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        addr    = a;
        wdata   = d;
        wenable = 1'b1;
        tick();
        wenable = 1'b0;
    endtask

    task automatic expect_mei(input string name, input logic v);
        exp_t x;
        x.name = name;
        x.val  = {31'b0, v};
        mei_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; addr = '0; wdata = '0; wenable = 1'b0; renable = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        expect_mei("mei_reset", 1'b0);

        // Reset state of every register, then field-width boundaries.
        for (int i = 1; i <= 8; i++) rd(12'(4 * i), 32'h0);
        rd(12'h080, 32'h0);
        rd(12'h100, 32'h0);
        rd(12'h200, 32'h0);
        rd(12'h204, 32'h0);
        expect_mei("mei_idle", 1'b0);
        wr(12'h004, 32'hFFFF_FFFF); rd(12'h004, 32'h7);
        wr(12'h100, 32'hFFFF_FFFF); rd(12'h100, 32'h1FE);
        wr(12'h300, 32'hDEAD_BEEF); rd(12'h300, 32'h0);
        wr(12'h000, 32'hFFFF_FFFF); rd(12'h000, 32'h0);
        wr(12'h004, 32'h0);
        wr(12'h100, 32'h0);

        // Single source: two-cycle latency, claim drops the line.
        wr(12'h00C, 32'h2); wr(12'h100, 32'h08); wr(12'h200, 32'h0);
        irq_src = 8'h04;
        tick(); expect_mei("mei_rise_edge", 1'b0);
        tick(); expect_mei("mei_rise_plus1", 1'b1);
        rd(12'h204, 32'd3);
        expect_mei("mei_after_claim", 1'b0);
        rd(12'h080, 32'h0);
        irq_src = 8'h00;
        wr(12'h204, 32'd3);

        // Priority ordering with a tie broken by lowest ID.
        wr(12'h008, 32'd5); wr(12'h014, 32'd5); wr(12'h01C, 32'd6); wr(12'h100, 32'hA4);
        irq_src = 8'h52;
        tick(); tick(); expect_mei("mei_three", 1'b1);
        rd(12'h080, 32'hA4);
        rd(12'h204, 32'd7);
        rd(12'h204, 32'd2);
        rd(12'h204, 32'd5);
        expect_mei("mei_drained", 1'b0);
        rd(12'h204, 32'd0);
        irq_src = 8'h00;
        wr(12'h204, 32'd7); wr(12'h204, 32'd2); wr(12'h204, 32'd5);
        rd(12'h080, 32'h0);

        // Threshold equal to priority masks the source.
        wr(12'h200, 32'd5); wr(12'h010, 32'd5); wr(12'h100, 32'h10);
        irq_src = 8'h08;
        tick(); tick(); expect_mei("mei_at_threshold", 1'b0);
        rd(12'h204, 32'd0);
        rd(12'h080, 32'h10);
        wr(12'h200, 32'd4);
        tick(); expect_mei("mei_threshold_lowered", 1'b1);
        rd(12'h204, 32'd4);
        irq_src = 8'h00;
        wr(12'h204, 32'd4);

        // Wrong-ID complete is ignored; right one re-arms a held source.
        wr(12'h200, 32'd0); wr(12'h100, 32'h08);
        irq_src = 8'h04;
        tick(); tick();
        rd(12'h204, 32'd3);
        rd(12'h080, 32'h0);
        wr(12'h204, 32'd6);
        rd(12'h080, 32'h0);
        wr(12'h204, 32'd3);
        rd(12'h080, 32'h0);
        rd(12'h080, 32'h08);
        rd(12'h204, 32'd3);

        // Reset while source 1 is inflight and the line is up.
        wr(12'h004, 32'd1); wr(12'h100, 32'h0A);
        irq_src = 8'h05;
        tick(); tick();
        rd(12'h204, 32'd1);
        wr(12'h204, 32'd3);
        tick(); tick(); expect_mei("mei_before_rst", 1'b1);
        rst = 1'b1;
        tick(); expect_mei("mei_after_rst", 1'b0);
        rst = 1'b0;
        rd(12'h080, 32'h0);
        rd(12'h080, 32'h0A);
        rd(12'h100, 32'h0);
        rd(12'h004, 32'h0);
        rd(12'h204, 32'd0);
        expect_mei("mei_post_rst", 1'b0);

        tick(); tick(); tick();
        if (rd_q.size() != 0 || mei_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain rd_left=%0d mei_left=%0d required=0", rd_q.size(), mei_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/plic_lite.md
# plic_lite

Platform-level interrupt arbiter that merges up to `NSRC` level-triggered external interrupt sources into the single machine external interrupt line feeding the CPU CSR file's `mei_pending` input. It sits on the memory-mapped peripheral bus. Each source has:
- a per-source gateway,
- a programmable priority and enable,
- a global threshold,
- a claim/complete handshake, so the M-mode trap handler can service the highest-priority source and re-arm it.

## Interface
- `NSRC`, 8: number of sources, IDs 1..NSRC (ID 0 = "none"); legal range 1..31
- `PRIO_W`, 3: priority width; priority 0 = never interrupts
- `XLEN`, 32: bus data width
- `clk` in 1: single clock; everything is on the rising edge
- `rst` in 1: reset is synchronous and active-high
- `irq_src` in NSRC: level interrupt inputs; bit i-1 = source ID i; already synchronous to `clk`
- `addr` in 12: byte address, word-aligned; bits [1:0] ignored
- `wdata` in XLEN: write data
- `wenable` in 1: write strobe, one access per cycle
- `renable` in 1: read strobe; ignored when `wenable`=1 in the same cycle
- `rdata` out XLEN: read data, valid the cycle after `renable`
- `mei_pending` out 1: registered; drives CSR file `mei_pending`

## Operation
- Register map (word offsets as byte addresses):
  - 0x000+4*i, i=1..NSRC: `priority[i]`, RW, low PRIO_W bits; upper bits are write-ignored and read 0.
  - 0x080: `pending`, RO; bit i = pending[i]; bit 0 and bits above NSRC read 0.
  - 0x100: `enable`, RW; bit 0 and bits above NSRC are forced 0.
  - 0x200: `threshold`, RW, PRIO_W bits.
  - 0x204: `claim/complete`. A read is a claim; a write is a complete.
  - Any other address reads 0; writes to it are dropped.
- Gateway per source, state `{pending, inflight}`:
  - IDLE (0,0) → PEND (1,0) when `irq_src` is high.
  - PEND → INFL (0,1) on a claim returning this ID.
  - INFL → IDLE on a complete whose `wdata` equals this ID.
  - If the source is still high on that complete, it re-enters PEND the next cycle.
  - A source is never pending and inflight at once.
  - Source edges while INFL are ignored.
- Arbitration is combinational over sources with pending=1, enable=1 and priority > threshold.
  - Winner = highest priority; ties go to the lowest ID.
  - `best_id` = 0 if there are no candidates.
- Claim (a read of 0x204):
  - `rdata` = `best_id`, captured in the read cycle.
  - That source moves PEND→INFL at the same edge.
  - A claim with `best_id`=0 changes no state.
- Complete (a write to 0x204):
  - ID = `wdata`[4:0].
  - Ignored if ID=0, ID>NSRC, or the source is not INFL.
- `mei_pending` next = (`best_id` != 0), computed from the post-update state. It therefore deasserts the cycle after a claim empties the candidate set.
- Enable, priority and threshold writes do not alter pending or inflight. They only change candidacy.
- Simultaneous gateway events on one edge:
  - A source rising at the claim edge of a different ID enters PEND normally.
  - A complete write and a source rising for the same ID on one edge leave the source IDLE, then PEND the next cycle.

## Timing
- Reset (`rst`=1 at an edge): all priorities, `enable`, `threshold`, pending and inflight are cleared; `rdata`=0; `mei_pending`=0. Reset mid-claim or mid-inflight discards the claim. Sources still high re-pend the cycle after `rst` drops.
- `irq_src` rise at edge N: pending=1 after edge N; `mei_pending`=1 after edge N+1 if the source is a candidate. Two-cycle source-to-line latency.
- Read latency is 1 cycle. `rdata` holds its value until the next read; non-read cycles do not change it.
- Back-to-back claims on consecutive cycles each see the state left by the previous edge.
- Complete takes effect at the write edge. The next claim may then return the same ID at the earliest 2 cycles later, because the gateway re-pends one cycle after the complete.

## Test plan
- Reset, then read every register → all 0; `mei_pending`=0 throughout.
- prio[3]=2, enable=0x08, threshold=0; raise `irq_src`[2] → `mei_pending`=1 two cycles later; claim → `rdata`=3; `mei_pending`=0 the cycle after; pending reads 0x0.
- prio[2]=5, prio[5]=5, prio[7]=6, all enabled, all three raised → claims return 7, then 2, then 5, then 0.
- threshold=5 with prio[4]=5 pending → `mei_pending`=0 and claim returns 0. Write threshold=4 → `mei_pending`=1 the cycle after.
- Claim ID 3 with source held high → complete with `wdata`=6 is ignored and pending stays 0. Complete with 3 → source 3 pending 1 cycle later and claimable again.
- Assert `rst` while source 1 is inflight and `mei_pending`=1 → all state cleared and `mei_pending`=0 the next cycle.
